mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Non-memory instructions pass their ALU result straight through.
- Loads and stores run a request/acknowledge transaction to a variable-latency data memory. The pipeline is stalled until the access completes.
- Handles byte, half and word accesses: alignment checks, byte enables, store data replication, load sign/zero extension, and a bus timeout.

---
 rtl/mem_stage_pkg.sv | 9 +
 rtl/lsu_align.sv | 35 +++
 rtl/mem_stage_lsu.sv | 124 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: funct3 access-size codes and LSU state encoding shared by the MEM stage
package mem_stage_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane formatting (offset/funct3/store data/read word in; byte enables, replicated store data, extended load data, misalign flag out)
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic        legal;
  assign lbyte = rword_i[{off_i, 3'b000} +: 8];
  assign lhalf = rword_i[{off_i[1], 4'b0000} +: 16];
  always_comb begin
    legal = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misalign_o = !legal || (store_i && funct3_i[2]) ||
                 (funct3_i[1:0] == 2'b01 && off_i[0]) ||
                 (funct3_i[1:0] == 2'b10 && off_i != 2'b00);
    be_o = !store_i ? 4'b1111 :
           funct3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
           funct3_i[1:0] == 2'b01 ? 4'b0011 << off_i : 4'b1111;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{sdata_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{sdata_i[15:0]}} : sdata_i;
    ldata_o = funct3_i == F3_B  ? {{24{lbyte[7]}}, lbyte} :
              funct3_i == F3_BU ? {24'b0, lbyte} :
              funct3_i == F3_H  ? {{16{lhalf[15]}}, lhalf} :
              funct3_i == F3_HU ? {16'b0, lhalf} : rword_i;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage LSU (ex_* from EX/MEM, dmem_* req/ack bus, mem_* to MEM/WB, stall/misalign_exc/bus_err to hazard unit; rst async active-low)
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rdst_id,
  input  logic        ex_we_reg,
  input  logic        ex_re_dmem,
  input  logic        ex_we_dmem,
  input  logic [2:0]  ex_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_rdata,
  output logic [4:0]  mem_rdst_id,
  output logic        mem_we_reg,
  output logic        mem_we_dmem,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d, bubble_q, bubble_d;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_ldata;
  logic          al_mis, mem_op, go, expired;
  lsu_align u_align (
    .off_i      (ex_alu_result[1:0]),
    .funct3_i   (ex_funct3),
    .store_i    (ex_we_dmem),
    .sdata_i    (ex_wdata),
    .rword_i    (dmem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_mis)
  );
  assign mem_op  = ex_valid && (ex_re_dmem || ex_we_dmem);
  assign go      = mem_op && !al_mis;
  assign expired = !dmem_ack && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    bubble_d = bubble_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = ACCESS;
        addr_d  = {ex_alu_result[31:2], 2'b00};
        we_d    = ex_we_dmem;
        wdata_d = al_wdata;
        be_d    = al_be;
      end
      ACCESS: if (dmem_ack) begin
        state_d  = DONE;
        rdata_d  = al_ldata;
        bubble_d = 1'b0;
      end else if (expired) begin
        state_d  = DONE;
        rdata_d  = '0;
        bubble_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      bubble_q <= bubble_d;
    end
  end
  assign dmem_req     = state_q == ACCESS;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign stall        = rst && ((state_q == IDLE && go) || state_q == ACCESS);
  assign misalign_exc = rst && state_q == IDLE && mem_op && al_mis;
  assign bus_err      = state_q == ACCESS && expired;
  assign mem_rdata    = state_q == DONE ? rdata_q : ex_alu_result;
  assign mem_rdst_id  = ex_rdst_id;
  assign mem_we_reg   = ex_valid && ex_we_reg &&
                        (state_q == IDLE ? !mem_op : state_q == DONE && ex_re_dmem && !bubble_q);
  assign mem_we_dmem  = ex_valid && state_q == DONE && ex_we_dmem && !bubble_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vector table plus randomized ops checked against a transaction-level model
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_we_reg, ex_re_dmem, ex_we_dmem;
  logic [31:0] ex_alu_result, ex_wdata;
  logic [4:0]  ex_rdst_id;
  logic [2:0]  ex_funct3;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  mem_rdst_id;
  logic        mem_we_reg, mem_we_dmem, stall, misalign_exc, bus_err;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_wdata(ex_wdata), .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg),
    .ex_re_dmem(ex_re_dmem), .ex_we_dmem(ex_we_dmem), .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_rdata(mem_rdata), .mem_rdst_id(mem_rdst_id),
    .mem_we_reg(mem_we_reg), .mem_we_dmem(mem_we_dmem), .stall(stall),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );
  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        we_reg, re, we;
    logic [2:0]  f3;
    int          lat;
    logic [31:0] rword;
    logic [31:0] e_rdata;
    logic        e_chk, e_we_reg, e_we_dmem, e_mis;
    int          e_stall;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;
  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask
  function automatic vec_t dv(input logic valid, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] rd, input logic we_reg, input logic re, input logic we,
                              input logic [2:0] f3, input int lat, input logic [31:0] rword,
                              input logic [31:0] e_rdata, input logic e_chk, input logic e_we_reg,
                              input logic e_we_dmem, input logic e_mis, input int e_stall,
                              input logic [3:0] e_be, input logic [31:0] e_wd);
    vec_t v;
    v.valid = valid; v.alu = alu; v.wd = wd; v.rd = rd; v.we_reg = we_reg; v.re = re; v.we = we;
    v.f3 = f3; v.lat = lat; v.rword = rword; v.e_rdata = e_rdata; v.e_chk = e_chk;
    v.e_we_reg = e_we_reg; v.e_we_dmem = e_we_dmem; v.e_mis = e_mis; v.e_stall = e_stall;
    v.e_be = e_be; v.e_wd = e_wd;
    return v;
  endfunction
  function automatic vec_t model(input vec_t v);
    int     off, size;
    longint p, mask;
    bit     memop, legal, mis, tmo, sgn;
    off   = int'(v.alu & 32'd3);
    size  = (v.f3 & 3'd3) == 0 ? 1 : (v.f3 & 3'd3) == 1 ? 2 : 4;
    legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    memop = v.valid && (v.re || v.we);
    mis   = memop && (!legal || (v.we && v.f3 > 3'd2) || (off % size) != 0);
    tmo   = v.lat >= TO;
    v.e_mis     = mis;
    v.e_stall   = (!memop || mis) ? 0 : tmo ? TO + 1 : v.lat + 2;
    v.e_we_reg  = v.valid && v.we_reg && (!memop || (v.re && !mis && !tmo));
    v.e_we_dmem = memop && v.we && !mis && !tmo;
    v.e_be      = !v.we ? 4'hF : size == 1 ? 4'(1 << off) : size == 2 ? 4'(3 << off) : 4'hF;
    v.e_wd      = size == 1 ? (v.wd & 32'hFF) * 32'h01010101 :
                  size == 2 ? (v.wd & 32'hFFFF) * 32'h00010001 : v.wd;
    mask = size == 1 ? 64'hFF : size == 2 ? 64'hFFFF : 64'hFFFF_FFFF;
    sgn  = v.f3 < 3'd4 && size < 4;
    p    = longint'(v.rword >> (8 * off)) & mask;
    if (sgn && p > mask / 2) p = p - (mask + 1);
    v.e_chk   = !memop || (v.re && !mis && !tmo);
    v.e_rdata = !memop ? v.alu : 32'(p);
    return v;
  endfunction
  task automatic apply(input vec_t v, input string tag);
    int n, acc;
    bit done;
    ex_valid = v.valid; ex_alu_result = v.alu; ex_wdata = v.wd; ex_rdst_id = v.rd;
    ex_we_reg = v.we_reg; ex_re_dmem = v.re; ex_we_dmem = v.we; ex_funct3 = v.f3;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    if (v.e_stall == 0) begin
      chk(tag, "stall", stall, 0);
      chk(tag, "dmem_req", dmem_req, 0);
      chk(tag, "misalign_exc", misalign_exc, v.e_mis);
      chk(tag, "mem_we_reg", mem_we_reg, v.e_we_reg);
      chk(tag, "mem_we_dmem", mem_we_dmem, 0);
      chk(tag, "mem_rdst_id", mem_rdst_id, v.rd);
      if (v.e_chk) chk(tag, "mem_rdata", mem_rdata, v.e_rdata);
    end else begin
      chk(tag, "idle_stall", stall, 1);
      chk(tag, "idle_req", dmem_req, 0);
      chk(tag, "idle_we_reg", mem_we_reg, 0);
      chk(tag, "idle_misalign", misalign_exc, 0);
      n = 1; acc = 0; done = 0;
      @(posedge clk); #1;
      while (!done && n < 64) begin
        if (dmem_req) begin
          if (acc == 0) begin
            chk(tag, "dmem_addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
            chk(tag, "dmem_we", dmem_we, v.we);
            chk(tag, "dmem_be", dmem_be, v.e_be);
            if (v.we) chk(tag, "dmem_wdata", dmem_wdata, v.e_wd);
          end
          dmem_ack = acc == v.lat;
          if (dmem_ack) dmem_rdata = v.rword;
          #1;
          chk(tag, "bus_err", bus_err, !dmem_ack && acc == TO - 1);
          chk(tag, "access_stall", stall, 1);
          acc++; n++;
          @(posedge clk); #1;
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end else done = 1;
      end
      if (!done) begin
        checks++; failures++;
        $display("FAIL %s done_bound: got no DONE within 64 cycles expected DONE", tag);
      end
      chk(tag, "stall_cycles", n, v.e_stall);
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      chk(tag, "done_stall", stall, 0);
      chk(tag, "done_req", dmem_req, 0);
      chk(tag, "done_bus_err", bus_err, 0);
      chk(tag, "done_we_reg", mem_we_reg, v.e_we_reg);
      chk(tag, "done_we_dmem", mem_we_dmem, v.e_we_dmem);
      chk(tag, "done_rdst", mem_rdst_id, v.rd);
      if (v.e_chk) chk(tag, "done_rdata", mem_rdata, v.e_rdata);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask
  vec_t dir[$];
  initial begin
    vec_t v;
    dir.push_back(dv(1, 32'h1234, 0, 5, 1, 0, 0, F3_B, 0, 0, 32'h1234, 1, 1, 0, 0, 0, 0, 0));
    dir.push_back(dv(1, 32'h103, 0, 7, 1, 1, 0, F3_B, 0, 32'h80FF_0000, 32'hFFFF_FF80, 1, 1, 0, 0, 2, 4'hF, 0));
    dir.push_back(dv(1, 32'h103, 0, 7, 1, 1, 0, F3_BU, 0, 32'h80FF_0000, 32'h0000_0080, 1, 1, 0, 0, 2, 4'hF, 0));
    dir.push_back(dv(1, 32'h202, 32'hABCD, 2, 1, 0, 1, F3_H, 3, 0, 0, 0, 0, 1, 0, 5, 4'b1100, 32'hABCD_ABCD));
    dir.push_back(dv(1, 32'h006, 0, 3, 1, 1, 0, F3_W, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    dir.push_back(dv(1, 32'h300, 0, 4, 1, 1, 0, F3_W, 99, 0, 0, 0, 0, 0, 0, 17, 4'hF, 0));
    dir.push_back(dv(1, 32'hDEAD_BEEF, 0, 9, 1, 0, 0, F3_W, 0, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 0, 0));
    dir.push_back(dv(0, 32'h55, 0, 1, 1, 1, 0, F3_W, 0, 0, 32'h55, 1, 0, 0, 0, 0, 0, 0));
    dir.push_back(dv(1, 32'h0, 0, 1, 1, 1, 0, 3'b011, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    dir.push_back(dv(1, 32'h0, 0, 1, 0, 0, 1, F3_BU, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    dir.push_back(dv(1, 32'h102, 0, 6, 1, 1, 0, F3_H, 1, 32'h8001_0000, 32'hFFFF_8001, 1, 1, 0, 0, 3, 4'hF, 0));
    dir.push_back(dv(1, 32'h102, 0, 6, 1, 1, 0, F3_HU, 1, 32'h8001_0000, 32'h0000_8001, 1, 1, 0, 0, 3, 4'hF, 0));
    dir.push_back(dv(1, 32'h101, 32'h1234_5678, 8, 0, 0, 1, F3_B, 0, 0, 0, 0, 0, 1, 0, 2, 4'b0010, 32'h7878_7878));
    dir.push_back(dv(1, 32'h40, 32'hCAFE_F00D, 8, 0, 0, 1, F3_W, 2, 0, 0, 0, 0, 1, 0, 4, 4'hF, 32'hCAFE_F00D));
    dir.push_back(dv(1, 32'h44, 0, 10, 1, 1, 0, F3_W, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 1, 1, 0, 0, 2, 4'hF, 0));
    rst = 1'b0; ex_valid = 0; ex_alu_result = 0; ex_wdata = 0; ex_rdst_id = 0;
    ex_we_reg = 0; ex_re_dmem = 0; ex_we_dmem = 0; ex_funct3 = 0; dmem_ack = 0; dmem_rdata = 0;
    #12;
    chk("reset", "dmem_req", dmem_req, 0);
    chk("reset", "dmem_we", dmem_we, 0);
    chk("reset", "dmem_addr", dmem_addr, 0);
    chk("reset", "dmem_wdata", dmem_wdata, 0);
    chk("reset", "dmem_be", dmem_be, 0);
    chk("reset", "stall", stall, 0);
    chk("reset", "misalign_exc", misalign_exc, 0);
    chk("reset", "bus_err", bus_err, 0);
    chk("reset", "mem_rdata", mem_rdata, 0);
    chk("reset", "mem_we_reg", mem_we_reg, 0);
    chk("reset", "mem_we_dmem", mem_we_dmem, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < dir.size(); i++) apply(dir[i], $sformatf("dir%0d", i));
    ex_valid = 1; ex_alu_result = 32'h10; ex_rdst_id = 11; ex_we_reg = 1;
    ex_re_dmem = 1; ex_we_dmem = 0; ex_funct3 = F3_W; dmem_ack = 0;
    #1;
    chk("rst_mid", "idle_stall", stall, 1);
    @(posedge clk); #1;
    chk("rst_mid", "access_req", dmem_req, 1);
    #1; rst = 1'b0; #1;
    chk("rst_mid", "req_drop", dmem_req, 0);
    chk("rst_mid", "stall_drop", stall, 0);
    chk("rst_mid", "addr_clear", dmem_addr, 0);
    chk("rst_mid", "be_clear", dmem_be, 0);
    ex_valid = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    apply(dv(1, 32'h10, 0, 11, 1, 1, 0, F3_W, 1, 32'h1357_9BDF, 32'h1357_9BDF, 1, 1, 0, 0, 3, 4'hF, 0), "rst_after");
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      v.valid  = kind != 3 || $urandom_range(0, 1) == 1;
      v.alu    = $urandom;
      v.wd     = $urandom;
      v.rd     = 5'($urandom);
      v.we_reg = 1'($urandom);
      v.re     = kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1);
      v.we     = kind == 2;
      v.f3     = $urandom_range(0, 5) == 0 ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (v.f3 != 3'd2 && $urandom_range(0, 1) == 1) v.f3 = v.f3 | 3'b100;
      v.lat    = $urandom_range(0, 9) == 0 ? 99 : int'($urandom_range(0, 4));
      v.rword  = $urandom;
      apply(model(v), $sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
